// File: rtl/mem_stage_pkg.sv
// Shared definitions for the M stage: load/store opcodes and the memory-access decode.
package mem_stage_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int AW_DEF    = 10;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  typedef enum logic [3:0] {
    ACC_NONE,
    ACC_LW,
    ACC_LB,
    ACC_LBU,
    ACC_LH,
    ACC_LHU,
    ACC_SW,
    ACC_SB,
    ACC_SH
  } mem_acc_e;

  function automatic mem_acc_e decode_acc(input logic [5:0] op);
    mem_acc_e acc;
    case (op)
      OP_LW:   acc = ACC_LW;
      OP_LB:   acc = ACC_LB;
      OP_LBU:  acc = ACC_LBU;
      OP_LH:   acc = ACC_LH;
      OP_LHU:  acc = ACC_LHU;
      OP_SW:   acc = ACC_SW;
      OP_SB:   acc = ACC_SB;
      OP_SH:   acc = ACC_SH;
      default: acc = ACC_NONE;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// E->M pipeline inputs, W-stage forward inputs and the M-stage outputs of the memory stage.
// No handshake: the pipeline advances every cycle and a bubble is simply IR_E == 0.
interface mem_stage_if;
  logic [31:0] IR_E;
  logic [31:0] PC8_E;
  logic [31:0] C_E;
  logic [31:0] RT_E;
  logic [31:0] WD_W;
  logic [4:0]  A3_W;
  logic        RegWrite_W;
  logic [31:0] IR_M;
  logic [31:0] PC8_M;
  logic [31:0] C_M;
  logic [31:0] DM_OUT;

  modport master (
    output IR_E, PC8_E, C_E, RT_E, WD_W, A3_W, RegWrite_W,
    input  IR_M, PC8_M, C_M, DM_OUT
  );

  modport slave (
    input  IR_E, PC8_E, C_E, RT_E, WD_W, A3_W, RegWrite_W,
    output IR_M, PC8_M, C_M, DM_OUT
  );
endinterface

// File: rtl/mem_stage_dm_byte_ram.sv
// Data memory: DEPTH x 32 words, byte-enabled synchronous write, asynchronous read,
// synchronous clear on reset. Emits the store trace on every committed write.
module dm_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic [31:0]   trace_pc,
  input  logic [31:0]   trace_addr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] merged;

  assign rdata = mem_q[addr];

  // Unselected lanes keep the current word so the trace shows the full merged value.
  always_comb begin
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (|be) begin
      mem_q[addr] <= merged;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", trace_pc, trace_addr, merged);
`endif
    end
  end

endmodule

// File: rtl/mem_stage.sv
// M stage: E->M pipeline registers, W->M store-data forward, byte/half lane handling
// around the data memory, and load extension.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);

  logic [31:0] ir_d, ir_q;
  logic [31:0] pc8_d, pc8_q;
  logic [31:0] c_d, c_q;
  logic [31:0] rt_d, rt_q;

  always_comb begin
    ir_d  = bus.IR_E;
    pc8_d = bus.PC8_E;
    c_d   = bus.C_E;
    rt_d  = bus.RT_E;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= 32'd0;
      pc8_q <= 32'd0;
      c_q   <= 32'd0;
      rt_q  <= 32'd0;
    end else begin
      ir_q  <= ir_d;
      pc8_q <= pc8_d;
      c_q   <= c_d;
      rt_q  <= rt_d;
    end
  end

  assign bus.IR_M  = ir_q;
  assign bus.PC8_M = pc8_q;
  assign bus.C_M   = c_q;

  mem_acc_e    acc;
  logic        fwd_hit;
  logic [31:0] store_data;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] dm_out;

  assign acc        = decode_acc(ir_q[31:26]);
  // The W-stage write has not reached the register file yet, so rt may be stale.
  assign fwd_hit    = bus.RegWrite_W && (bus.A3_W != 5'd0) && (bus.A3_W == ir_q[20:16]);
  assign store_data = fwd_hit ? bus.WD_W : rt_q;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (acc)
      ACC_SW: be = 4'b1111;
      ACC_SH: begin
        be    = c_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      ACC_SB: begin
        be    = 4'b0001 << c_q[1:0];
        wdata = {4{store_data[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  dm_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk        (clk),
    .reset      (reset),
    .addr       (c_q[AW+1:2]),
    .be         (be),
    .wdata      (wdata),
    .trace_pc   (pc8_q - 32'd8),
    .trace_addr ({c_q[31:2], 2'b00}),
    .rdata      (rdata)
  );

  always_comb begin
    byte_sel = rdata[8*c_q[1:0] +: 8];
    half_sel = c_q[1] ? rdata[31:16] : rdata[15:0];
    case (acc)
      ACC_LW:  dm_out = rdata;
      ACC_LB:  dm_out = {{24{byte_sel[7]}}, byte_sel};
      ACC_LBU: dm_out = {24'd0, byte_sel};
      ACC_LH:  dm_out = {{16{half_sel[15]}}, half_sel};
      ACC_LHU: dm_out = {16'd0, half_sel};
      default: dm_out = 32'd0;
    endcase
  end

  assign bus.DM_OUT = dm_out;

endmodule
